aoi_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 9-input AND-OR-INVERT gate.
- Evaluates GROUPS product terms of TERMS inputs each.
- Function is selectable per transaction: AOI, AO, OAI or OA.
- Valid/ready handshakes on both sides; used as a registered logic-function slice in the TI products datapath.

---
 rtl/aoi_pipe.sv | 82 ++++++++
 tb/tb_aoi_pipe.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/aoi_pipe.sv
// aoi_pipe: two-stage valid/ready AOI/AO/OAI/OA slice over GROUPS x TERMS operands.
// Optional output toggle counter enabled by defining AOI_TOGGLE_CNT_EN.
module aoi_pipe #(
  parameter int GROUPS = 3,
  parameter int TERMS  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [GROUPS*TERMS-1:0]   IN_DATA,
  input  logic [1:0]                IN_MODE,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  output logic                      Y,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY
`ifdef AOI_TOGGLE_CNT_EN
  ,
  input  logic                      CNT_CLR,
  output logic [CNT_W-1:0]          TOGGLE_CNT
`endif
);
  logic                    s1_v_q, s2_v_q, y_q, y_d;
  logic [GROUPS*TERMS-1:0] s1_data_q;
  logic [1:0]              s1_mode_q;
  logic [GROUPS-1:0]       and_v, or_v;
  logic                    s1_load, s2_load;

  for (genvar g = 0; g < GROUPS; g++) begin : grp
    assign and_v[g] = &s1_data_q[g*TERMS +: TERMS];
    assign or_v[g]  = |s1_data_q[g*TERMS +: TERMS];
  end

  // mode[1] picks product-of-sums, mode[0] clear means inverted output
  always_comb begin
    y_d = s1_mode_q[1] ? &or_v : |and_v;
    y_d = s1_mode_q[0] ? y_d : ~y_d;
  end

  assign s2_load  = s1_v_q && (!s2_v_q || OUT_READY);
  assign s1_load  = !s1_v_q || s2_load;
  assign IN_READY = RST_N && s1_load;
  assign Y         = y_q;
  assign OUT_VALID = s2_v_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_mode_q <= '0;
      s2_v_q    <= 1'b0;
      y_q       <= 1'b0;
    end else begin
      if (s1_load) s1_v_q <= IN_VALID;
      if (s1_load && IN_VALID) begin
        s1_data_q <= IN_DATA;
        s1_mode_q <= IN_MODE;
      end
      s2_v_q <= s2_load || (s2_v_q && !OUT_READY);
      if (s2_load) y_q <= y_d;
    end
  end

`ifdef AOI_TOGGLE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             prev_q, hs;
  assign hs = s2_v_q && OUT_READY;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else if (CNT_CLR) begin
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else if (hs) begin
      prev_q <= y_q;
      if (y_q != prev_q && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end
  assign TOGGLE_CNT = cnt_q;
`endif
endmodule

// File: tb/tb_aoi_pipe.sv
// tb_aoi_pipe: table vectors, directed corner sequences and a random scoreboard run for aoi_pipe.
module tb_aoi_pipe;
  localparam int G = 3;
  localparam int T = 3;
`ifdef AOI_TOGGLE_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic         CLK = 0, RST_N = 0;
  logic [G*T-1:0] IN_DATA = '0;
  logic [1:0]   IN_MODE = '0;
  logic         IN_VALID = 0, OUT_READY = 0;
  logic         IN_READY, Y, OUT_VALID;
`ifdef AOI_TOGGLE_CNT_EN
  logic         CNT_CLR = 0;
  logic [CW-1:0] TOGGLE_CNT;
`endif

  int nvec = 0, nerr = 0;
  logic q[$];

  aoi_pipe #(.GROUPS(G), .TERMS(T), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_DATA(IN_DATA), .IN_MODE(IN_MODE),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .Y(Y), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY)
`ifdef AOI_TOGGLE_CNT_EN
    , .CNT_CLR(CNT_CLR), .TOGGLE_CNT(TOGGLE_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  // Sum of products is true when some group is all ones; product of sums when every group has a one.
  function automatic logic model(input logic [G*T-1:0] d, input logic [1:0] m);
    int full, any, ones;
    logic r;
    full = 0;
    any = 0;
    for (int g = 0; g < G; g++) begin
      ones = 0;
      for (int t = 0; t < T; t++) ones += int'(d[g*T+t]);
      if (ones == T) full++;
      if (ones > 0) any++;
    end
    r = m[1] ? (any == G) : (full > 0);
    return m[0] ? r : !r;
  endfunction

  always @(negedge CLK) if (RST_N) begin
    if (OUT_VALID && OUT_READY) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL sb_extra: got unexpected output Y=%0b, expected none at %0t", Y, $time);
      end else check("sb_y", Y, q.pop_front());
    end
    if (IN_VALID && IN_READY) q.push_back(model(IN_DATA, IN_MODE));
  end

  task automatic send_one(input logic [G*T-1:0] d, input logic [1:0] m, input logic e);
    @(posedge CLK); #1;
    IN_DATA = d; IN_MODE = m; IN_VALID = 1; OUT_READY = 1;
    @(negedge CLK); check("acc_ready", IN_READY, 1);
    @(posedge CLK); #1;
    IN_VALID = 0;
    @(negedge CLK); check("lat1_valid", OUT_VALID, 0);
    @(negedge CLK); check("lat2_valid", OUT_VALID, 1); check("lat2_y", Y, e);
  endtask

  typedef struct { logic [G*T-1:0] d; logic [1:0] m; logic y; } vec_t;
  vec_t tab[9];

  initial begin
    tab[0] = '{9'h000, 2'b00, 1'b1};
    tab[1] = '{9'h007, 2'b00, 1'b0};
    tab[2] = '{9'h1C0, 2'b00, 1'b0};
    tab[3] = '{9'h1FF, 2'b00, 1'b0};
    tab[4] = '{9'h1FF, 2'b01, 1'b1};
    tab[5] = '{9'h1FF, 2'b10, 1'b0};
    tab[6] = '{9'h1FF, 2'b11, 1'b1};
    tab[7] = '{9'h049, 2'b10, 1'b0};
    tab[8] = '{9'h049, 2'b11, 1'b1};

    #1;
    check("rst_valid", OUT_VALID, 0);
    check("rst_y", Y, 0);
    @(posedge CLK); #1 RST_N = 1;

    foreach (tab[i]) send_one(tab[i].d, tab[i].m, tab[i].y);

    // Backpressure: three pushes, only two held.
    @(posedge CLK); #1;
    OUT_READY = 0; IN_VALID = 1; IN_DATA = 9'h000; IN_MODE = 2'b00;
    @(negedge CLK); check("bp_rdy0", IN_READY, 1);
    @(posedge CLK); #1 IN_DATA = 9'h007;
    @(negedge CLK); check("bp_rdy1", IN_READY, 1);
    @(posedge CLK); #1 IN_DATA = 9'h000;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("bp_full_rdy", IN_READY, 0);
      check("bp_hold_valid", OUT_VALID, 1);
      check("bp_hold_y", Y, 1);
    end
    @(posedge CLK); #1 OUT_READY = 1;
    @(negedge CLK); check("bp_release_rdy", IN_READY, 1);
    @(posedge CLK); #1 IN_VALID = 0;
    @(negedge CLK); check("bp_out2_valid", OUT_VALID, 1); check("bp_out2_y", Y, 0);
    @(negedge CLK); check("bp_out3_valid", OUT_VALID, 1); check("bp_out3_y", Y, 1);
    @(negedge CLK); check("bp_empty", OUT_VALID, 0);

    // Streaming with alternating modes.
    for (int i = 0; i < 22; i++) begin
      @(posedge CLK); #1;
      IN_VALID = (i < 20); IN_DATA = 9'($urandom); IN_MODE = 2'(i % 4); OUT_READY = 1;
      @(negedge CLK);
      if (i < 20) check("st_ready", IN_READY, 1);
      if (i >= 2) check("st_valid", OUT_VALID, 1);
    end
    @(posedge CLK); #1 IN_VALID = 0;
    @(negedge CLK); check("st_done", OUT_VALID, 0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK); #1;
      IN_VALID = 1'($urandom); OUT_READY = ($urandom_range(3) != 0);
      IN_DATA = 9'($urandom); IN_MODE = 2'($urandom);
    end
    @(posedge CLK); #1 IN_VALID = 0; OUT_READY = 1;
    repeat (4) @(negedge CLK);
    check("drain_empty", q.size(), 0);

    // Reset with both stages full.
    @(posedge CLK); #1;
    OUT_READY = 0; IN_VALID = 1; IN_DATA = 9'h000; IN_MODE = 2'b00;
    @(posedge CLK); #1 IN_DATA = 9'h007;
    @(posedge CLK); #1 IN_VALID = 0;
    @(negedge CLK); check("pre_rst_valid", OUT_VALID, 1); check("pre_rst_y", Y, 1);
    #2 RST_N = 0;
    #1 check("mid_rst_valid", OUT_VALID, 0); check("mid_rst_y", Y, 0);
    q.delete();
    @(posedge CLK); #1 RST_N = 1;
    send_one(9'h1FF, 2'b01, 1);

`ifdef AOI_TOGGLE_CNT_EN
    begin
      logic [G*T-1:0] td[5];
      logic [CW-1:0]  tc[5];
      td = '{9'h000, 9'h000, 9'h007, 9'h000, 9'h007};
      tc = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
      @(posedge CLK); #1 CNT_CLR = 1;
      @(posedge CLK); #1 CNT_CLR = 0;
      @(negedge CLK); check("cnt_clr", TOGGLE_CNT, 0);
      for (int i = 0; i < 5; i++) begin
        send_one(td[i], 2'b00, model(td[i], 2'b00));
        @(negedge CLK); check("cnt_val", TOGGLE_CNT, tc[i]);
      end
      send_one(9'h000, 2'b00, 1);
      CNT_CLR = 1;
      @(negedge CLK); check("cnt_clr_prio", TOGGLE_CNT, 0);
      CNT_CLR = 0;
    end
`endif

    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
